// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous input into the clk domain and debounces it with a
// stability counter, producing a clean registered level plus rise/fall/bounce pulses.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic bounce
);

    localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
    localparam logic [1:0] ST_CHECK_HIGH  = 2'd1;
    localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
    localparam logic [1:0] ST_CHECK_LOW   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             bounce_q, bounce_d;

    assign s = sync_q[SYNC_STAGES-1];

    // The synchronizer ignores en so the FSM always resumes from a current view of din.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        bounce_d = 1'b0;
        if (en) begin
            case (state_q)
                ST_STABLE_LOW: begin
                    if (s) begin
                        state_d = ST_CHECK_HIGH;
                        cnt_d   = '0;
                    end
                end
                ST_CHECK_HIGH: begin
                    if (!s) begin
                        state_d  = ST_STABLE_LOW;
                        bounce_d = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE_HIGH;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE_HIGH: begin
                    if (!s) begin
                        state_d = ST_CHECK_LOW;
                        cnt_d   = '0;
                    end
                end
                ST_CHECK_LOW: begin
                    if (s) begin
                        state_d  = ST_STABLE_HIGH;
                        bounce_d = 1'b1;
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE_LOW;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE_LOW;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_STABLE_LOW;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            bounce_q <= bounce_d;
        end
    end

    assign dout   = dout_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign bounce = bounce_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default config (A) and SYNC_STAGES=3/DEBOUNCE_CYCLES=1 (B),
// checked every cycle against a run-length model plus literal expectations.
module tb_debounce_sync;

    localparam int SA = 2;
    localparam int DA = 16;
    localparam int SB = 3;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic din_a, din_b;
    logic dout_a, rise_a, fall_a, bounce_a;
    logic dout_b, rise_b, fall_b, bounce_b;

    int tests = 0;
    int bad   = 0;

    int n_rise_a = 0, n_fall_a = 0, n_bounce_a = 0;
    int n_rise_b = 0, n_fall_b = 0, n_bounce_b = 0;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA)) u_dut_a (
        .clk(clk), .reset(reset), .din(din_a), .en(en),
        .dout(dout_a), .rise(rise_a), .fall(fall_a), .bounce(bounce_a)
    );

    debounce_sync #(.SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB)) u_dut_b (
        .clk(clk), .reset(reset), .din(din_b), .en(1'b1),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .bounce(bounce_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // A new level is accepted once it has been seen on D+1 consecutive enabled edges;
    // seeing the old level again after any such run is a bounce.
    task automatic model_step(input int d, input bit s, input bit e, inout int run,
                              inout bit lvl, output bit r, output bit f, output bit b);
        r = 1'b0; f = 1'b0; b = 1'b0;
        if (e) begin
            if (s != lvl) begin
                run++;
                if (run == d + 1) begin
                    lvl = s;
                    r   = s;
                    f   = !s;
                    run = 0;
                end
            end else if (run > 0) begin
                b   = 1'b1;
                run = 0;
            end
        end
    endtask

    bit q_a[$];
    bit q_b[$];
    int run_a, run_b;
    bit [3:0] m_a, m_b;

    always @(posedge clk or negedge reset) begin : model
        bit s, lvl, r, f, b;
        int run;
        if (!reset) begin
            q_a.delete();
            q_b.delete();
            for (int i = 0; i < SA; i++) q_a.push_back(1'b0);
            for (int i = 0; i < SB; i++) q_b.push_back(1'b0);
            run_a <= 0;
            run_b <= 0;
            m_a   <= '0;
            m_b   <= '0;
        end else begin
            s = q_a.pop_front();
            q_a.push_back(din_a);
            run = run_a; lvl = m_a[3];
            model_step(DA, s, en, run, lvl, r, f, b);
            run_a <= run;
            m_a   <= {lvl, r, f, b};

            s = q_b.pop_front();
            q_b.push_back(din_b);
            run = run_b; lvl = m_b[3];
            model_step(DB, s, 1'b1, run, lvl, r, f, b);
            run_b <= run;
            m_b   <= {lvl, r, f, b};
        end
    end

    always @(negedge clk) begin
        check("cycle_a", {4'd0, dout_a, rise_a, fall_a, bounce_a}, {4'd0, m_a});
        check("cycle_b", {4'd0, dout_b, rise_b, fall_b, bounce_b}, {4'd0, m_b});
        n_rise_a   += int'(rise_a === 1'b1);
        n_fall_a   += int'(fall_a === 1'b1);
        n_bounce_a += int'(bounce_a === 1'b1);
        n_rise_b   += int'(rise_b === 1'b1);
        n_fall_b   += int'(fall_b === 1'b1);
        n_bounce_b += int'(bounce_b === 1'b1);
    end

    initial begin
        int snap;
        din_a = 1'b0;
        din_b = 1'b0;
        en    = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("reset_a", {4'd0, dout_a, rise_a, fall_a, bounce_a}, 8'h00);
        check("reset_b", {4'd0, dout_b, rise_b, fall_b, bounce_b}, 8'h00);
        tick(3);
        reset = 1'b1;

        // Idle low: nothing may happen.
        tick(50);
        check("idle_pulses", 8'(n_rise_a + n_fall_a + n_bounce_a), 8'd0);
        check("idle_dout", {7'd0, dout_a}, 8'd0);

        // Clean rise then clean fall, each landing on edge 19.
        din_a = 1'b1;
        tick(18);
        check("rise_e18", {6'd0, dout_a, rise_a}, 8'b00);
        tick(1);
        check("rise_e19", {6'd0, dout_a, rise_a}, 8'b11);
        tick(1);
        check("rise_e20", {6'd0, dout_a, rise_a}, 8'b10);
        din_a = 1'b0;
        tick(18);
        check("fall_e18", {6'd0, dout_a, fall_a}, 8'b10);
        tick(1);
        check("fall_e19", {6'd0, dout_a, fall_a}, 8'b01);
        tick(1);
        check("fall_e20", {6'd0, dout_a, fall_a}, 8'b00);

        // 10-cycle high glitch: single bounce on edge 13.
        din_a = 1'b1;
        tick(10);
        din_a = 1'b0;
        tick(2);
        check("glitch_e12", {7'd0, bounce_a}, 8'd0);
        tick(1);
        check("glitch_e13", {6'd0, dout_a, bounce_a}, 8'b01);
        tick(1);
        check("glitch_e14", {7'd0, bounce_a}, 8'd0);
        tick(20);
        check("glitch_count", 8'(n_bounce_a), 8'd1);

        // Freeze at cnt=8 for 20 edges; acceptance 8 edges after en returns.
        din_a = 1'b1;
        tick(11);
        en   = 1'b0;
        snap = n_rise_a + n_fall_a + n_bounce_a;
        tick(20);
        check("freeze_pulses", 8'(n_rise_a + n_fall_a + n_bounce_a - snap), 8'd0);
        check("freeze_dout", {7'd0, dout_a}, 8'd0);
        en = 1'b1;
        tick(7);
        check("resume_7", {6'd0, dout_a, rise_a}, 8'b00);
        tick(1);
        check("resume_8", {6'd0, dout_a, rise_a}, 8'b11);
        din_a = 1'b0;
        tick(25);
        check("resume_fall", {7'd0, dout_a}, 8'd0);

        // Reset at cnt=12 discards the pending rise; full latency after release.
        din_a = 1'b1;
        tick(15);
        snap  = n_rise_a;
        reset = 1'b0;
        #1 check("midreset_a", {4'd0, dout_a, rise_a, fall_a, bounce_a}, 8'h00);
        tick(2);
        reset = 1'b1;
        tick(18);
        check("postreset_e18", {6'd0, dout_a, rise_a}, 8'b00);
        check("postreset_norise", 8'(n_rise_a - snap), 8'd0);
        tick(1);
        check("postreset_e19", {6'd0, dout_a, rise_a}, 8'b11);
        din_a = 1'b0;
        tick(25);

        // Config B: 1-cycle glitch bounces; 2-cycle high accepted on edge 5.
        din_b = 1'b1;
        tick(1);
        din_b = 1'b0;
        tick(3);
        check("b_glitch_e4", {6'd0, dout_b, bounce_b}, 8'b00);
        tick(1);
        check("b_glitch_e5", {6'd0, dout_b, bounce_b}, 8'b01);
        tick(10);
        din_b = 1'b1;
        tick(2);
        din_b = 1'b0;
        tick(3);
        check("b_rise_e5", {6'd0, dout_b, rise_b}, 8'b11);
        tick(2);
        check("b_fall_e7", {6'd0, dout_b, fall_b}, 8'b01);
        tick(5);

        check("total_rise_a", 8'(n_rise_a), 8'd3);
        check("total_fall_a", 8'(n_fall_a), 8'd3);
        check("total_bounce_a", 8'(n_bounce_a), 8'd1);
        check("total_b", {2'd0, 2'(n_rise_b), 2'(n_fall_b), 2'(n_bounce_b)}, 8'b00_01_01_01);

        $display("test done: total=%0d bad=%0d", tests, bad);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input-conditioning stage directly upstream of the level-sensitive data latch. Takes a raw asynchronous single-bit input (switch, button, off-chip strobe), synchronizes it into the `clk` domain, and debounces it with a stability counter. It drives a clean level (`dout`) to the latch's data input, plus one-cycle edge and bounce pulses for control logic.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a new level; legal ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width; derived, not overridden.

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `din` input 1: raw asynchronous input, no timing relation to `clk`.
- `en` input 1: debounce enable; 0 freezes FSM/counter.
- `dout` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse on the cycle `dout` goes 0→1.
- `fall` output 1: one-cycle pulse on the cycle `dout` goes 1→0.
- `bounce` output 1: one-cycle pulse when a pending transition is aborted.

## Operation
- Synchronizer:
  - `SYNC_STAGES` flops in series, `din` → stage 1.
  - `s` is the last stage output.
  - The chain runs every cycle regardless of `en`.
- FSM has four states. `cnt` is the `CNT_W`-bit counter.
  - STABLE_LOW: `dout`=0. If `s`=1, go to CHECK_HIGH and set `cnt`=0.
  - CHECK_HIGH:
    - `dout`=0.
    - If `s`=0: return to STABLE_LOW, `bounce`=1, `cnt`=0.
    - Else if `cnt`==`DEBOUNCE_CYCLES`-1: go to STABLE_HIGH, `dout`=1, `rise`=1.
    - Else `cnt`++.
  - STABLE_HIGH: `dout`=1. If `s`=0, go to CHECK_LOW and set `cnt`=0.
  - CHECK_LOW: mirror of CHECK_HIGH. Abort on `s`=1 goes to STABLE_HIGH with `bounce`=1. On completion: `dout`=0, `fall`=1.
- `dout`, `rise`, `fall` and `bounce` are registered outputs, updated on the same edge as the state transition.
- Pulses are high for exactly one cycle. At most one pulse is high in any cycle.
- `en`=0:
  - State, `cnt` and `dout` hold.
  - `rise`/`fall`/`bounce` are 0.
  - When `en` returns to 1, evaluation resumes from the held state and count.
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1 and never wraps. It is 0 in both STABLE states.

## Timing
- Reset (`reset`=0, asynchronous, takes effect immediately):
  - All sync flops 0, state STABLE_LOW, `cnt`=0.
  - `dout`=0, `rise`=0, `fall`=0, `bounce`=0.
- Reset asserted mid-CHECK discards the pending transition. No pulse is emitted.
- After deassertion, the first rising edge performs normal evaluation.
- Latency:
  - Number edges from edge 1, the first edge that samples a new `din` level held stable.
  - `s` changes after edge `SYNC_STAGES`.
  - The FSM enters CHECK on edge `SYNC_STAGES`+1.
  - `dout` and its pulse update after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1.
  - Defaults: edge 19.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES`+1 consecutive cycles of `s` at the new level. Anything shorter produces only `bounce`.
- A return to the old level on the final CHECK cycle (when `cnt`==`DEBOUNCE_CYCLES`-1) is an abort (`bounce`), not an accept.
- `DEBOUNCE_CYCLES`=1: the transition is accepted on the second cycle `s` is seen at the new level.

## Test plan
- Reset then hold `din`=0 for 50 cycles → `dout`=0; `rise`, `fall`, `bounce` never asserted.
- Defaults; `din` 0→1 sampled at edge 1 and held → `dout`=1 and `rise`=1 for one cycle after edge 19. Then `din`→0 → `fall` one cycle, 19 edges later.
- `din` high for 10 cycles, then low → exactly one `bounce` pulse; `dout` stays 0; FSM back in STABLE_LOW.
- `din` high and stable; drop `en` to 0 at `cnt`=8 for 20 cycles, then restore → `dout` rises 8 cycles after `en` returns (cnt 8→15 then accept); no pulse while `en`=0.
- Assert `reset` at `cnt`=12 in CHECK_HIGH with `din` still high → outputs 0 immediately. After release, `dout` rises only after a full `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 edges.
- `DEBOUNCE_CYCLES`=1, `SYNC_STAGES`=3; 1-cycle `din` glitch → `bounce` only. 2-cycle high → `rise` after edge 5.
